// File: rtl/noc_pkg.sv
// noc_pkg: shared packet type, field positions and field-extraction helpers
package noc_pkg;
  localparam int PKT_WIDTH = 33;
  localparam int DEST_MSB = 32;
  localparam int DEST_LSB = 29;
  localparam int SRC_MSB = 28;
  localparam int SRC_LSB = 25;
  localparam int PAYLOAD_MSB = 24;
  localparam int PAYLOAD_LSB = 0;
  typedef logic [PKT_WIDTH-1:0] packet_t;
  function automatic logic [DEST_MSB-DEST_LSB:0] pkt_dest(input packet_t p);
    return p[DEST_MSB:DEST_LSB];
  endfunction
  function automatic logic [SRC_MSB-SRC_LSB:0] pkt_src(input packet_t p);
    return p[SRC_MSB:SRC_LSB];
  endfunction
  function automatic logic [PAYLOAD_MSB-PAYLOAD_LSB:0] pkt_payload(input packet_t p);
    return p[PAYLOAD_MSB:PAYLOAD_LSB];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: pointer-based FIFO storage; caller guarantees push only when not full, pop only when not empty
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= wdata;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/packet_egress_buffer.sv
// packet_egress_buffer: FIFO-buffered egress stage sending under credit flow control
// with a registered output, sent-packet counter and sticky credit-overflow flag.
module packet_egress_buffer
  import noc_pkg::*;
#(
  parameter int WIDTH = PKT_WIDTH,
  parameter int DEPTH = 4,
  parameter int CREDITS = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         credit_return,
  output logic [$clog2(CREDITS+1)-1:0] credits,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             pkt_sent,
  output logic                         err_credit
);
  localparam int CW = $clog2(CREDITS+1);
  logic push, pop, full, empty, ovf;
  logic [WIDTH-1:0] head;
  logic [CW-1:0] credits_q, credits_d;
  logic [CNT_W-1:0] pkt_sent_q, pkt_sent_d;
  logic out_valid_q, err_q;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(in_data),
    .rdata(head), .count(occupancy), .full(full), .empty(empty)
  );
  // Both handshake decisions use registered state only: a pop never frees space for a same-edge push.
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = !empty && credits_q != '0;
  always_comb begin
    ovf = credit_return && credits_q == CW'(CREDITS) && !pop;
    credits_d = ovf ? credits_q : credits_q - CW'(pop) + CW'(credit_return);
    pkt_sent_d = pkt_sent_q + CNT_W'(pop);
    out_data_d = pop ? head : out_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CW'(CREDITS);
      pkt_sent_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      pkt_sent_q <= pkt_sent_d;
      out_valid_q <= pop;
      out_data_q <= out_data_d;
      err_q <= err_q || ovf;
    end
  end
  assign credits = credits_q;
  assign pkt_sent = pkt_sent_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign err_credit = err_q;
endmodule

// File: doc/packet_egress_buffer.md
Name: packet_egress_buffer

Overview:
- Clocked egress stage directly downstream of the two-input arbiter/merge.
- Accepts merged 33-bit packets over a valid/ready handshake and buffers them in a FIFO.
- Forwards packets onto the outgoing link under credit-based flow control, one packet per cycle at most.
- Keeps a sent-packet counter and a sticky credit-overflow error flag.

Parameters:
- WIDTH, 33, packet width in bits; must equal noc_pkg::PKT_WIDTH.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CREDITS, 4, initial and maximum downstream credits; at least 1.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream packet present.
- in_ready  out  1  buffer can accept a packet this cycle.
- in_data  in  WIDTH  packet from the merge stage.
- out_valid  out  1  one-cycle pulse; out_data is valid this cycle.
- out_data  out  WIDTH  registered outgoing packet.
- credit_return  in  1  one-cycle pulse; downstream has freed one slot.
- credits  out  $clog2(CREDITS+1)  current credit count.
- occupancy  out  $clog2(DEPTH+1)  FIFO entry count.
- pkt_sent  out  CNT_W  packets sent since reset; wraps modulo 2^CNT_W.
- err_credit  out  1  sticky; set when credit_return arrives while credits==CREDITS.

Behaviour:
- Reset (async assert, sync release):
  - occupancy=0, read/write pointers=0, credits=CREDITS.
  - out_valid=0, out_data=0, pkt_sent=0, err_credit=0.
  - FIFO contents are discarded. Reset mid-stream drops all buffered packets and any in-flight out_valid.
- Input handshake:
  - in_ready = (occupancy != DEPTH), combinational from registered state only; never depends on in_valid.
  - Push occurs on an edge where in_valid && in_ready.
  - When full, no push is accepted even if a pop happens on the same edge; in_ready rises the cycle after the pop.
  - in_data must be held stable while in_valid && !in_ready. The block does not check this.
- Pop / send:
  - pop = (occupancy != 0) && (credits != 0), evaluated from registered state.
  - On a pop edge: out_data <= FIFO head, out_valid <= 1, read pointer advances, pkt_sent increments.
  - Otherwise out_valid <= 0 and out_data holds its last value.
  - Back-to-back pops give one packet per cycle with out_valid held high.
- Latency: a packet accepted into an empty FIFO at edge k, with credits>0, is on out_data with out_valid=1 between edges k+1 and k+2. Minimum latency is 1 cycle after acceptance; no bypass path.
- Ordering: strict FIFO. Packets are never reordered, dropped or duplicated except by reset.
- Credits:
  - next = credits - pop + credit_return.
  - Pop and return on the same edge leaves credits unchanged.
  - A return while credits==CREDITS and no pop is ignored and sets err_credit; credits stay at CREDITS.
  - At credits==0 no send occurs. A credit_return at that edge allows a send at the following edge.
- Occupancy: next = occupancy + push - pop. Simultaneous push and pop leaves it unchanged.
- Pointers: width $clog2(DEPTH), wrap naturally from DEPTH-1 to 0.
- No combinational path from in_valid to any output, or from credit_return to out_valid.

Decomposition:
- noc_pkg holds:
  - PKT_WIDTH=33 and typedef logic [32:0] packet_t.
  - Field positions DEST_MSB=32, DEST_LSB=29, SRC_MSB=28, SRC_LSB=25, PAYLOAD_MSB=24, PAYLOAD_LSB=0.
  - Field-extraction functions. This block does not interpret fields; they are shared for bench checking.
- Sub-module sync_fifo (WIDTH, DEPTH) provides storage, pointers, occupancy, full and empty.
- packet_egress_buffer wraps sync_fifo and adds the credit counter, output register, pkt_sent counter and err_credit.

Test Plan:
- Single packet: push 33'h1_2345_6789 at edge k with credits=4 -> out_valid=1 for exactly one cycle after edge k+1, out_data=33'h1_2345_6789, credits=3, pkt_sent=1.
- Credit starvation: no credit_return, push 6 packets -> exactly 4 out_valid pulses, credits=0, occupancy=2. Then 2 credit_return pulses -> remaining 2 packets sent in order, occupancy=0.
- Full FIFO: hold credits=0 (send 4 packets first), push until in_ready=0 -> occupancy=4. A further in_valid is not accepted until a credit_return-triggered pop, and in_ready=1 the cycle after that pop.
- Simultaneous events: steady push each cycle with credit_return each cycle after warm-up -> credits constant, occupancy constant, out_valid continuously high, 100 packets received in order.
- Credit overflow: after reset, pulse credit_return with no traffic -> err_credit=1 and stays 1, credits=4.
- Reset mid-stream: assert rst asynchronously with occupancy=3 and out_valid=1 -> all outputs at reset values immediately, no out_valid after release until a new push.
